// File: rtl/dct_block_sequencer.sv
// dct_block_sequencer
// Walks the capture buffer in 8x8 blocks in raster block order. For each block
// it reads the 64 pixels into the mcu register, latches the combinational DCT
// result for that mcu, and streams the 64 coefficients out over valid/ready.
module dct_block_sequencer #(
  parameter int IMG_W  = 224,
  parameter int IMG_H  = 224,
  parameter int ADDR_W = 16,
  parameter int BLK_W  = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [7:0]        pix_data,
  output logic [511:0]      mcu,
  input  logic [1023:0]     dct_coef,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic [15:0]       coef_data,
  output logic [BLK_W-1:0]  coef_blk,
  output logic [5:0]        coef_idx,
  output logic              coef_last
);

  localparam int BLK_X = IMG_W / 8;
  localparam int BLK_Y = IMG_H / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_STREAM  = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t            state_reg;
  state_t            state_next;

  // Fetch read counter: 0..63 issue reads, 64 is the drain cycle for the last byte.
  logic [6:0]        k_reg;
  // Read-return pipeline: which mcu byte the incoming pix_data belongs to.
  logic              rd_d_reg;
  logic [5:0]        wr_k_reg;

  logic [BLK_W-1:0]  bx_reg;
  logic [BLK_W-1:0]  by_reg;
  logic [BLK_W-1:0]  blk_reg;
  logic [5:0]        idx_reg;

  logic [511:0]      mcu_reg;
  logic [1023:0]     coef_buf_reg;
  logic [15:0]       coef_word [64];

  logic              handshake;
  logic              last_coef;
  logic              final_blk;
  logic              fetch_done;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] addr_calc;

  // Abort wins over the handshake, so a cancelled pass never advances idx or block.
  assign handshake  = (state_reg == S_STREAM) && coef_ready && !abort;
  assign last_coef  = (idx_reg == 6'd63);
  assign last_col   = (bx_reg == BLK_W'(BLK_X - 1));
  assign last_row   = (by_reg == BLK_W'(BLK_Y - 1));
  assign final_blk  = last_col && last_row;
  assign fetch_done = (k_reg == 7'd64);

  // Linear pixel address of read k within block (bx,by); unsigned, ADDR_W wide.
  assign addr_calc = (ADDR_W'(by_reg) * ADDR_W'(8) + ADDR_W'(k_reg[5:3])) * ADDR_W'(IMG_W)
                   + ADDR_W'(bx_reg) * ADDR_W'(8) + ADDR_W'(k_reg[2:0]);

  // Slice the coefficient buffer into words so the stream mux indexes by coefficient.
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_coef_word
      assign coef_word[gi] = coef_buf_reg[16*gi +: 16];
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; abort returns any active state to IDLE.
  always_comb begin
    state_next = state_reg;
    if (abort && (state_reg != S_IDLE)) begin
      state_next = S_IDLE;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) state_next = S_FETCH;
        end
        S_FETCH: begin
          if (fetch_done) state_next = S_CAPTURE;
        end
        S_CAPTURE: begin
          state_next = S_STREAM;
        end
        S_STREAM: begin
          if (handshake && last_coef) state_next = final_blk ? S_DONE : S_FETCH;
        end
        S_DONE: begin
          state_next = S_IDLE;
        end
        default: begin
          state_next = S_IDLE;
        end
      endcase
    end
  end

  // Control outputs decoded from the current state.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    pix_rd     = 1'b0;
    coef_valid = 1'b0;
    case (state_reg)
      S_FETCH: begin
        busy   = 1'b1;
        pix_rd = !k_reg[6];
      end
      S_CAPTURE: begin
        busy = 1'b1;
      end
      S_STREAM: begin
        busy       = 1'b1;
        coef_valid = 1'b1;
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Fetch counter runs only while staying in FETCH, so every entry starts at 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k_reg <= '0;
    end else if ((state_reg == S_FETCH) && (state_next == S_FETCH)) begin
      k_reg <= k_reg + 7'd1;
    end else begin
      k_reg <= '0;
    end
  end

  // Remember which byte each read targets; data returns one cycle later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_d_reg <= 1'b0;
      wr_k_reg <= '0;
    end else begin
      rd_d_reg <= pix_rd;
      wr_k_reg <= k_reg[5:0];
    end
  end

  // Assemble the block: returned pixel lands in mcu byte k.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcu_reg <= '0;
    end else if (rd_d_reg) begin
      mcu_reg[{wr_k_reg, 3'b000} +: 8] <= pix_data;
    end
  end

  // Latch all 64 DCT coefficients in the single CAPTURE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      coef_buf_reg <= '0;
    end else if (state_reg == S_CAPTURE) begin
      coef_buf_reg <= dct_coef;
    end
  end

  // Block position and stream index; advance on handshakes, restart on start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bx_reg  <= '0;
      by_reg  <= '0;
      blk_reg <= '0;
      idx_reg <= '0;
    end else if ((state_reg == S_IDLE) && start) begin
      bx_reg  <= '0;
      by_reg  <= '0;
      blk_reg <= '0;
      idx_reg <= '0;
    end else if (handshake) begin
      idx_reg <= idx_reg + 6'd1;
      if (last_coef) begin
        if (last_col) begin
          bx_reg <= '0;
          by_reg <= last_row ? '0 : by_reg + BLK_W'(1);
        end else begin
          bx_reg <= bx_reg + BLK_W'(1);
        end
        blk_reg <= final_blk ? '0 : blk_reg + BLK_W'(1);
      end
    end
  end

  assign pix_addr  = pix_rd ? addr_calc : '0;
  assign mcu       = mcu_reg;
  assign coef_data = coef_word[idx_reg];
  assign coef_blk  = blk_reg;
  assign coef_idx  = idx_reg;
  assign coef_last = coef_valid && final_blk && last_coef;

endmodule

// File: tb/tb_dct_block_sequencer.sv
// tb_dct_block_sequencer
// Two instances: a 16x16 image (4 blocks, full frame to done) and the default
// 224x224 image (addressing, backpressure, ignored start, abort, async reset).
// RAM model returns addr%256; DCT model is coef k = {pix[k], pix[63-k]^k}.
module tb_dct_block_sequencer;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic start   = 1'b0;
  logic abort   = 1'b0;
  logic ready   = 1'b1;
  logic sel     = 1'b0;   // 1: small instance, 0: default instance

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // default-size instance signals
  logic          b_start, b_abort, b_busy, b_done, b_pix_rd, b_valid, b_last;
  logic [15:0]   b_pix_addr, b_data;
  logic [7:0]    b_pix_data = 8'h00;
  logic [511:0]  b_mcu;
  logic [1023:0] b_dct;
  logic [9:0]    b_blk;
  logic [5:0]    b_idx;

  // small instance signals
  logic          s_start, s_abort, s_busy, s_done, s_pix_rd, s_valid, s_last;
  logic [15:0]   s_pix_addr, s_data;
  logic [7:0]    s_pix_data = 8'h00;
  logic [511:0]  s_mcu;
  logic [1023:0] s_dct;
  logic [9:0]    s_blk;
  logic [5:0]    s_idx;

  assign b_start = sel ? 1'b0 : start;
  assign b_abort = sel ? 1'b0 : abort;
  assign s_start = sel ? start : 1'b0;
  assign s_abort = sel ? abort : 1'b0;

  dct_block_sequencer #(.IMG_W(224), .IMG_H(224), .ADDR_W(16), .BLK_W(10)) dut (
    .clk(clk), .reset_n(reset_n), .start(b_start), .abort(b_abort),
    .busy(b_busy), .done(b_done), .pix_rd(b_pix_rd), .pix_addr(b_pix_addr),
    .pix_data(b_pix_data), .mcu(b_mcu), .dct_coef(b_dct),
    .coef_valid(b_valid), .coef_ready(ready), .coef_data(b_data),
    .coef_blk(b_blk), .coef_idx(b_idx), .coef_last(b_last)
  );

  dct_block_sequencer #(.IMG_W(16), .IMG_H(16), .ADDR_W(16), .BLK_W(10)) dut_small (
    .clk(clk), .reset_n(reset_n), .start(s_start), .abort(s_abort),
    .busy(s_busy), .done(s_done), .pix_rd(s_pix_rd), .pix_addr(s_pix_addr),
    .pix_data(s_pix_data), .mcu(s_mcu), .dct_coef(s_dct),
    .coef_valid(s_valid), .coef_ready(ready), .coef_data(s_data),
    .coef_blk(s_blk), .coef_idx(s_idx), .coef_last(s_last)
  );

  // RAM models: data one cycle after the read strobe, RAM[a] = a % 256
  always @(posedge clk) begin
    b_pix_data <= b_pix_rd ? b_pix_addr[7:0] : 8'h00;
    s_pix_data <= s_pix_rd ? s_pix_addr[7:0] : 8'h00;
  end

  // DCT stand-in models, combinational from mcu
  generate
    for (genvar gi = 0; gi < 64; gi++) begin : g_dct
      assign b_dct[16*gi +: 16] = {b_mcu[8*gi +: 8], b_mcu[8*(63-gi) +: 8] ^ 8'(gi)};
      assign s_dct[16*gi +: 16] = {s_mcu[8*gi +: 8], s_mcu[8*(63-gi) +: 8] ^ 8'(gi)};
    end
  endgenerate

  // observed outputs of the selected instance
  logic         o_busy, o_done, o_pix_rd, o_valid, o_last;
  logic [15:0]  o_pix_addr, o_data;
  logic [511:0] o_mcu;
  logic [9:0]   o_blk;
  logic [5:0]   o_idx;
  assign o_busy     = sel ? s_busy     : b_busy;
  assign o_done     = sel ? s_done     : b_done;
  assign o_pix_rd   = sel ? s_pix_rd   : b_pix_rd;
  assign o_valid    = sel ? s_valid    : b_valid;
  assign o_last     = sel ? s_last     : b_last;
  assign o_pix_addr = sel ? s_pix_addr : b_pix_addr;
  assign o_data     = sel ? s_data     : b_data;
  assign o_mcu      = sel ? s_mcu      : b_mcu;
  assign o_blk      = sel ? s_blk      : b_blk;
  assign o_idx      = sel ? s_idx      : b_idx;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic int exp_addr(input int w, input int b, input int k);
    int bx;
    int by;
    bx = b % (w / 8);
    by = b / (w / 8);
    return (by * 8 + k / 8) * w + bx * 8 + k % 8;
  endfunction

  function automatic logic [15:0] exp_coef(input int w, input int b, input int k);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = 8'(exp_addr(w, b, k));
    lo = 8'(exp_addr(w, b, 63 - k)) ^ 8'(k);
    return {hi, lo};
  endfunction

  function automatic logic [511:0] exp_mcu(input int w, input int b);
    logic [511:0] m;
    m = '0;
    for (int k = 0; k < 64; k++) m[8*k +: 8] = 8'(exp_addr(w, b, k));
    return m;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},     512'(o_busy),     512'(0));
    check({tag, "_done"},     512'(o_done),     512'(0));
    check({tag, "_pix_rd"},   512'(o_pix_rd),   512'(0));
    check({tag, "_pix_addr"}, 512'(o_pix_addr), 512'(0));
    check({tag, "_mcu"},      o_mcu,            512'(0));
    check({tag, "_valid"},    512'(o_valid),    512'(0));
    check({tag, "_data"},     512'(o_data),     512'(0));
    check({tag, "_blk"},      512'(o_blk),      512'(0));
    check({tag, "_idx"},      512'(o_idx),      512'(0));
    check({tag, "_last"},     512'(o_last),     512'(0));
  endtask

  // One block: entered at the negedge of FETCH k=0, left at the negedge after
  // the idx-63 handshake (or after an abort / async reset at stop_idx).
  task automatic run_block(input int w, input int b, input bit last_blk, input int bp_idx,
                           input int start_k, input int stop_idx, input bit stop_rst);
    int idx;
    int hold;
    for (int k = 0; k <= 64; k++) begin
      if (k == 0) begin
        check("busy_fetch", 512'(o_busy), 512'(1));
        check("valid_fetch", 512'(o_valid), 512'(0));
      end
      if (k < 64) begin
        check("pix_rd", 512'(o_pix_rd), 512'(1));
        check("pix_addr", 512'(o_pix_addr), 512'(exp_addr(w, b, k)));
      end else begin
        check("pix_rd_drain", 512'(o_pix_rd), 512'(0));
      end
      start = (k == start_k);
      tick();
    end
    start = 1'b0;
    check("mcu", o_mcu, exp_mcu(w, b));
    check("valid_capture", 512'(o_valid), 512'(0));
    tick();
    idx  = 0;
    hold = 0;
    while (idx < 64) begin
      check("coef_valid", 512'(o_valid), 512'(1));
      check("coef_idx", 512'(o_idx), 512'(idx));
      check("coef_data", 512'(o_data), 512'(exp_coef(w, b, idx)));
      check("coef_blk", 512'(o_blk), 512'(b));
      check("coef_last", 512'(o_last), 512'(last_blk && idx == 63));
      if (idx == stop_idx) begin
        if (stop_rst) begin
          #2 reset_n = 1'b0;
          #1 check_all_zero("async_rst");
          @(posedge clk);
          #1 check("rst_hold_valid", 512'(o_valid), 512'(0));
          #1 reset_n = 1'b1;
          tick();
          check("rst_release_busy", 512'(o_busy), 512'(0));
          $display("block %0d (w=%0d) cut by reset at idx %0d", b, w, idx);
        end else begin
          abort = 1'b1;
          tick();
          abort = 1'b0;
          check("abort_valid", 512'(o_valid), 512'(0));
          check("abort_busy", 512'(o_busy), 512'(0));
          check("abort_pix_rd", 512'(o_pix_rd), 512'(0));
          for (int i = 0; i < 4; i++) begin
            check("abort_no_done", 512'(o_done), 512'(0));
            check("abort_idle", 512'(o_busy), 512'(0));
            tick();
          end
          $display("block %0d (w=%0d) aborted at idx %0d", b, w, idx);
        end
        return;
      end
      if (idx == bp_idx && hold < 5) begin
        ready = 1'b0;
        hold++;
      end else begin
        ready = 1'b1;
      end
      tick();
      if (ready) idx++;
    end
    ready = 1'b1;
    if (last_blk) begin
      check("done", 512'(o_done), 512'(1));
      check("busy_done", 512'(o_busy), 512'(0));
      check("valid_done", 512'(o_valid), 512'(0));
      start = 1'b1;               // start in the DONE cycle must be ignored
      tick();
      start = 1'b0;
      check("done_one_cycle", 512'(o_done), 512'(0));
      check("busy_after_done", 512'(o_busy), 512'(0));
      tick();
      check("start_in_done_ignored", 512'(o_busy), 512'(0));
      check("no_rd_after_done", 512'(o_pix_rd), 512'(0));
    end
    $display("block %0d (w=%0d) streamed, backpressure_idx=%0d", b, w, bp_idx);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // reset asserted from time 0; outputs of both instances must be zero
    #3;
    sel = 1'b0;
    #1 check_all_zero("reset_big");
    sel = 1'b1;
    #1 check_all_zero("reset_small");
    sel = 1'b0;
    #7 reset_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("idle_no_rd", 512'(o_pix_rd), 512'(0));
      check("idle_busy", 512'(o_busy), 512'(0));
      tick();
    end

    // full 16x16 frame: 4 blocks, raster order, coef_last and done
    sel = 1'b1;
    pulse_start();
    for (int b = 0; b < 4; b++) run_block(16, b, b == 3, -1, -1, -1, 1'b0);

    // 224x224: backpressure on block 0, ignored start in block 3, abort in block 28
    sel = 1'b0;
    tick();
    pulse_start();
    for (int b = 0; b <= 28; b++)
      run_block(224, b, 1'b0, (b == 0) ? 10 : -1, (b == 3) ? 5 : -1, (b == 28) ? 20 : -1, 1'b0);

    // restart, async reset during STREAM of block 5
    pulse_start();
    for (int b = 0; b <= 5; b++)
      run_block(224, b, 1'b0, -1, -1, (b == 5) ? 30 : -1, 1'b1);

    // pass restarts from block 0 after reset, then abort early in block 1
    pulse_start();
    run_block(224, 0, 1'b0, -1, -1, -1, 1'b0);
    run_block(224, 1, 1'b0, -1, -1, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
